// File: rtl/ysyx_220066_dmem_resp.sv
// Data-memory responder: doubleword RAM behind the core data port with configurable latency.
// Define DMEM_STRICT_ALIGN_EN to fault misaligned accesses; otherwise addresses are truncated to natural alignment.
module ysyx_220066_dmem_resp #(
  parameter int unsigned ADDR_W  = 16,
  parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [2:0]  MemOp,
  input  logic [63:0] addr,
  input  logic [63:0] data_Wr,
  output logic        req_ready,
  output logic [63:0] data_Rd,
  output logic        data_Rd_valid,
  output logic        data_Rd_error
);

  localparam int unsigned IDX_W = ADDR_W - 3;
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              rdy_nxt, valid_nxt, err_nxt;
  logic [63:0]       data_nxt;

  logic              req_rd, req_wr;
  logic [2:0]        req_op;
  logic [63:0]       req_addr, req_wdata;

  logic [63:0]       mem [DEPTH];

  logic [2:0]        amask;
  logic [63:0]       ea, off;
  logic              align_err, range_err, op_err, err_c;
  logic [IDX_W-1:0]  idx;
  logic [2:0]        lane;
  logic [63:0]       dw, shifted, load_val, wdata_sh;
  logic [7:0]        be_base, be;

  // Decode of the latched request: effective address, faults, load data, store lanes
  always_comb begin
    unique case (req_op[1:0])
      2'b00:   begin amask = 3'b000; be_base = 8'h01; end
      2'b01:   begin amask = 3'b001; be_base = 8'h03; end
      2'b10:   begin amask = 3'b011; be_base = 8'h0F; end
      default: begin amask = 3'b111; be_base = 8'hFF; end
    endcase
`ifdef DMEM_STRICT_ALIGN_EN
    ea        = req_addr;
    align_err = |(req_addr[2:0] & amask);
`else
    ea        = req_addr & ~{61'd0, amask};
    align_err = 1'b0;
`endif
    off       = ea - BASE;
    range_err = (ea < BASE) || (off[63:ADDR_W] != '0);
    op_err    = (req_op == 3'b111) || (req_wr && req_op[2]);
    err_c     = (req_rd && req_wr) || op_err || range_err || align_err;
    idx       = off[ADDR_W-1:3];
    lane      = off[2:0];
    dw        = mem[idx];
    shifted   = dw >> {lane, 3'b000};
    unique case (req_op[1:0])
      2'b00:   load_val = req_op[2] ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = req_op[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'b10:   load_val = req_op[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
    be       = be_base << lane;
    wdata_sh = req_wdata << {lane, 3'b000};
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (MemRd || MemWr) begin
          cnt_nxt   = CNT_W'(LATENCY - 1);
          state_nxt = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    rdy_nxt   = (state_nxt == IDLE);
    valid_nxt = (state == RESP);
    err_nxt   = (state == RESP) && err_c;
    data_nxt  = ((state == RESP) && !err_c && !req_wr) ? load_val : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      req_ready     <= 1'b1;
      data_Rd       <= '0;
      data_Rd_valid <= 1'b0;
      data_Rd_error <= 1'b0;
      req_rd        <= 1'b0;
      req_wr        <= 1'b0;
      req_op        <= '0;
      req_addr      <= '0;
      req_wdata     <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      req_ready     <= rdy_nxt;
      data_Rd       <= data_nxt;
      data_Rd_valid <= valid_nxt;
      data_Rd_error <= err_nxt;
      if (state == IDLE && (MemRd || MemWr)) begin
        req_rd    <= MemRd;
        req_wr    <= MemWr;
        req_op    <= MemOp;
        req_addr  <= addr;
        req_wdata <= data_Wr;
      end
    end
  end

  // RAM is not reset; byte-enabled store in the response cycle only
  always_ff @(posedge clk) begin
    if (rst && state == RESP && req_wr && !err_c) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_220066_dmem_resp.sv
// Directed self-checking bench for ysyx_220066_dmem_resp (ADDR_W=16, LATENCY=2).
module tb_ysyx_220066_dmem_resp;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam logic [2:0] OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010, OP_D = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100, OP_HU = 3'b101, OP_WU = 3'b110;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRd, MemWr;
  logic [2:0]  MemOp;
  logic [63:0] addr, data_Wr;
  logic        req_ready;
  logic [63:0] data_Rd;
  logic        data_Rd_valid, data_Rd_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_220066_dmem_resp #(.ADDR_W(16), .BASE(BASE), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .MemRd(MemRd), .MemWr(MemWr), .MemOp(MemOp),
    .addr(addr), .data_Wr(data_Wr), .req_ready(req_ready), .data_Rd(data_Rd),
    .data_Rd_valid(data_Rd_valid), .data_Rd_error(data_Rd_error)
  );

  // Issue one request from idle, scramble inputs after accept, wait for the response
  task automatic access(input logic rd, input logic wr, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] wd,
                        output logic [63:0] d, output logic e, output int lat);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_idle: got %b want 1", req_ready); end
    MemRd = rd; MemWr = wr; MemOp = op; addr = a; data_Wr = wd;
    @(posedge clk); #1;
    addr = ~a; data_Wr = ~wd;
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL ready_busy: got %b want 0", req_ready); end
    lat = 0; d = '0; e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (data_Rd_valid === 1'b1) begin lat = i; break; end
    end
    d = data_Rd; e = data_Rd_error;
    MemRd = 1'b0; MemWr = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (data_Rd_valid !== 1'b0) begin n_fail++; $display("FAIL valid_width: got %b want 0", data_Rd_valid); end
  endtask

  task automatic test_reset();
    rst = 1'b0; MemRd = 1'b0; MemWr = 1'b0; MemOp = '0; addr = '0; data_Wr = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    n_checks++; if (data_Rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", data_Rd_valid); end
    n_checks++; if (data_Rd_error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b want 0", data_Rd_error); end
    n_checks++; if (data_Rd !== 64'd0) begin n_fail++; $display("FAIL rst_data: got %h want 0", data_Rd); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    logic [63:0] d; logic e; int lat;
    access(1'b0, 1'b1, OP_D, BASE, 64'h8877_6655_4433_2211, d, e, lat);
    n_checks++; if (e !== 1'b0 || d !== 64'd0 || lat != 2) begin n_fail++; $display("FAIL sd_word0: got e=%b d=%h lat=%0d want e=0 d=0 lat=2", e, d, lat); end
    access(1'b1, 1'b0, OP_D, BASE, 64'd0, d, e, lat);
    n_checks++; if (d !== 64'h8877_6655_4433_2211) begin n_fail++; $display("FAIL ld_word0: got %h want 8877665544332211", d); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL ld_word0_err: got %b want 0", e); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL ld_latency: got %0d want 2", lat); end
  endtask

  task automatic test_extension();
    logic [63:0] d; logic e; int lat;
    access(1'b0, 1'b1, OP_B, BASE + 64'd3, 64'h0000_0000_0000_00F4, d, e, lat);
    access(1'b1, 1'b0, OP_B, BASE + 64'd3, 64'd0, d, e, lat);
    n_checks++; if (d !== 64'hFFFF_FFFF_FFFF_FFF4 || e !== 1'b0) begin n_fail++; $display("FAIL lb_sext: got %h e=%b want fffffffffffffff4", d, e); end
    access(1'b1, 1'b0, OP_BU, BASE + 64'd3, 64'd0, d, e, lat);
    n_checks++; if (d !== 64'h0000_0000_0000_00F4) begin n_fail++; $display("FAIL lbu_zext: got %h want f4", d); end
    access(1'b1, 1'b0, OP_H, BASE + 64'd2, 64'd0, d, e, lat);
    n_checks++; if (d !== 64'hFFFF_FFFF_FFFF_F433) begin n_fail++; $display("FAIL lh_sext: got %h want fffffffffffff433", d); end
    access(1'b0, 1'b1, OP_D, BASE, 64'h8877_6655_4433_2211, d, e, lat);
  endtask

  task automatic test_store_merge();
    logic [63:0] d; logic e; int lat;
    access(1'b0, 1'b1, OP_H, BASE + 64'd6, 64'h0000_0000_0000_ABCD, d, e, lat);
    n_checks++; if (e !== 1'b0 || d !== 64'd0) begin n_fail++; $display("FAIL sh_resp: got e=%b d=%h want e=0 d=0", e, d); end
    access(1'b1, 1'b0, OP_D, BASE, 64'd0, d, e, lat);
    n_checks++; if (d !== 64'hABCD_6655_4433_2211) begin n_fail++; $display("FAIL sh_merge: got %h want abcd665544332211", d); end
    access(1'b1, 1'b0, OP_W, BASE + 64'd4, 64'd0, d, e, lat);
    n_checks++; if (d !== 64'hFFFF_FFFF_ABCD_6655) begin n_fail++; $display("FAIL lw_sext: got %h want ffffffffabcd6655", d); end
    access(1'b1, 1'b0, OP_WU, BASE + 64'd4, 64'd0, d, e, lat);
    n_checks++; if (d !== 64'h0000_0000_ABCD_6655) begin n_fail++; $display("FAIL lwu_zext: got %h want abcd6655", d); end
    access(1'b1, 1'b0, OP_HU, BASE + 64'd6, 64'd0, d, e, lat);
    n_checks++; if (d !== 64'h0000_0000_0000_ABCD) begin n_fail++; $display("FAIL lhu_zext: got %h want abcd", d); end
  endtask

  task automatic test_errors();
    logic [63:0] d; logic e; int lat;
    access(1'b1, 1'b0, OP_D, 64'h0000_0000_7FFF_FFF8, 64'd0, d, e, lat);
    n_checks++; if (e !== 1'b1 || d !== 64'd0) begin n_fail++; $display("FAIL below_base: got e=%b d=%h want e=1 d=0", e, d); end
    access(1'b0, 1'b1, OP_D, BASE + 64'h1_0000, 64'h1111_2222_3333_4444, d, e, lat);
    n_checks++; if (e !== 1'b1 || lat != 2) begin n_fail++; $display("FAIL above_top: got e=%b lat=%0d want e=1 lat=2", e, lat); end
    access(1'b1, 1'b1, OP_D, BASE, 64'h5555_6666_7777_8888, d, e, lat);
    n_checks++; if (e !== 1'b1 || d !== 64'd0) begin n_fail++; $display("FAIL rd_and_wr: got e=%b d=%h want e=1 d=0", e, d); end
    access(1'b1, 1'b0, 3'b111, BASE, 64'd0, d, e, lat);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL op_111: got %b want 1", e); end
    access(1'b0, 1'b1, OP_BU, BASE, 64'h0000_0000_0000_0099, d, e, lat);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL store_unsigned_op: got %b want 1", e); end
    access(1'b1, 1'b0, OP_D, BASE, 64'd0, d, e, lat);
    n_checks++; if (d !== 64'hABCD_6655_4433_2211) begin n_fail++; $display("FAIL ram_untouched: got %h want abcd665544332211", d); end
    access(1'b0, 1'b1, OP_D, BASE + 64'hFFF8, 64'h0123_4567_89AB_CDEF, d, e, lat);
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL sd_last_dw: got %b want 0", e); end
    access(1'b1, 1'b0, OP_W, BASE + 64'hFFFC, 64'd0, d, e, lat);
    n_checks++; if (e !== 1'b0 || d !== 64'h0000_0000_0123_4567) begin n_fail++; $display("FAIL lw_top: got e=%b d=%h want e=0 d=01234567", e, d); end
  endtask

  task automatic test_align();
    logic [63:0] d; logic e; int lat;
    access(1'b1, 1'b0, OP_W, BASE + 64'd2, 64'd0, d, e, lat);
`ifdef DMEM_STRICT_ALIGN_EN
    n_checks++; if (e !== 1'b1 || d !== 64'd0) begin n_fail++; $display("FAIL lw_misalign: got e=%b d=%h want e=1 d=0", e, d); end
`else
    n_checks++; if (e !== 1'b0 || d !== 64'h0000_0000_4433_2211) begin n_fail++; $display("FAIL lw_truncate: got e=%b d=%h want e=0 d=44332211", e, d); end
`endif
    access(1'b1, 1'b0, OP_H, BASE + 64'd7, 64'd0, d, e, lat);
`ifdef DMEM_STRICT_ALIGN_EN
    n_checks++; if (e !== 1'b1 || d !== 64'd0) begin n_fail++; $display("FAIL lh_misalign: got e=%b d=%h want e=1 d=0", e, d); end
`else
    n_checks++; if (e !== 1'b0 || d !== 64'hFFFF_FFFF_FFFF_ABCD) begin n_fail++; $display("FAIL lh_truncate: got e=%b d=%h want e=0 d=ffffffffffffabcd", e, d); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [63:0] d; logic e; int lat; int seen;
    MemWr = 1'b1; MemOp = OP_D; addr = BASE; data_Wr = 64'hDEAD_BEEF_0000_0000;
    @(posedge clk); #1;
    MemWr = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 1", req_ready); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (data_Rd_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL mid_rst_no_resp: got %0d pulses want 0", seen); end
    access(1'b1, 1'b0, OP_D, BASE, 64'd0, d, e, lat);
    n_checks++; if (d !== 64'hABCD_6655_4433_2211) begin n_fail++; $display("FAIL mid_rst_ram: got %h want abcd665544332211", d); end
  endtask

  task automatic test_back_to_back();
    int hits[$];
    MemRd = 1'b1; MemOp = OP_D; addr = BASE;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (data_Rd_valid === 1'b1) begin
        hits.push_back(i);
        n_checks++; if (data_Rd !== 64'hABCD_6655_4433_2211) begin n_fail++; $display("FAIL b2b_data: got %h want abcd665544332211", data_Rd); end
        if (i >= 9) MemRd = 1'b0;
      end
    end
    MemRd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (hits.size() != 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d pulses want 3", hits.size());
    end else if (hits[0] != 3 || hits[1] != 6 || hits[2] != 9) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d,%0d,%0d want 3,6,9", hits[0], hits[1], hits[2]);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_extension();
    test_store_merge();
    test_errors();
    test_align();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
